switch_post_pw: RTL and testbench
=================================

SWITCH_POST_PW -- requirements
Module: switch_post_pw

Interface
REQ-001 SHALL have parameter OUT_BYTES, default 4, egress bytes per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter CELL_DEPTH, default 256, cell FIFO depth in 128-bit entries; must be a power of 2.
REQ-003 SHALL have parameter BP_MARGIN, default 16, free-entry count at which in_bp asserts.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_wr, input, 1, cell word write strobe.
REQ-007 SHALL have port in_din, input, 128, cell word; byte0 = [127:120].
REQ-008 SHALL have ports in_first and in_last, input, 1 each, first/last cell of frame, qualified by in_wr.
REQ-009 SHALL have port in_bp, output, 1, backpressure to switch core.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 8*OUT_BYTES), out_keep (output, OUT_BYTES), out_last (output, 1); together they form the egress byte stream.
REQ-011 SHALL have ports desc_valid (output, 1), desc_ready (input, 1), desc_len (output, 12); together they form the frame descriptor.
REQ-012 SHALL have ports err_orphan, err_trunc and err_zero, output, 1 each, one-cycle error pulses.

Function
REQ-013 SHALL buffer cells in a first-word-fall-through FIFO of CELL_DEPTH entries; in_bp is registered and set when free entries <= BP_MARGIN. Writes while full are dropped.
REQ-014 SHALL take the frame length from the first cell as len = {byte0[7:4], byte1}; frame payload starts at byte2.
REQ-015 SHALL run the FSM IDLE -> HDR -> STREAM -> (FLUSH) -> DESC -> IDLE; plus DROP.
REQ-016 IDLE: when the head is valid and not in_first, the FSM SHALL pop it, pulse err_orphan, and stay in IDLE.
REQ-017 IDLE: when the head is in_first and desc_valid is low, the FSM SHALL go to HDR.
REQ-018 HDR: the FSM SHALL latch len; if len==0 it SHALL pulse err_zero and go to DROP, else go to STREAM.
REQ-019 STREAM: packing rules.
- Emit payload bytes in order, packed from out_data LSB lane (lane0 = [7:0]).
- Each beat carries min(OUT_BYTES, remaining) bytes, may span two cells, and out_keep is contiguous from lane0.
- A beat advances only on out_valid & out_ready.
- out_data, out_keep and out_last SHALL hold stable while out_valid & !out_ready.
REQ-020 out_last SHALL mark the beat containing byte number len.
- If the head cell is in_last, go to DESC.
- Otherwise go to FLUSH, which pops cells through the in_last cell and discards them.
REQ-021 If an in_last cell is exhausted before len bytes have been emitted, the block SHALL:
- end the frame there, with out_last on the final available byte;
- pulse err_trunc;
- report desc_len = bytes actually emitted.
REQ-022 Bytes of the last cell beyond len SHALL be discarded.
REQ-023 DESC: the block SHALL assert desc_valid with desc_len = emitted byte count and hold it until desc_ready. desc_valid SHALL clear on the handshake cycle, and the FSM SHALL then return to IDLE. The FSM SHALL NOT start a new frame while desc_valid is high.
REQ-024 DROP: the FSM SHALL pop cells through the in_last cell, emit no beats and no descriptor, then return to IDLE.
REQ-025 Latency: first out_valid SHALL assert 2 clk after an in_first cell reaches the FIFO head in IDLE.
REQ-026 Throughput: sustained one beat per clk SHALL be held with out_ready high.
REQ-027 A cell SHALL be popped in the cycle its last used byte leaves, so FIFO pop and push in the same cycle are both honoured.

Reset
REQ-028 On rstn low the block SHALL force the FSM to IDLE and flush the cell FIFO.
REQ-029 On rstn low the block SHALL drive in_bp, out_valid, out_keep, out_last, desc_valid and all err_* outputs to 0, and out_data and desc_len to 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no descriptor; the first post-reset cell is treated per IDLE rules.

Configuration
REQ-031 Macro SWITCH_POST_PW_STATS_EN: when defined, the block SHALL add outputs stat_frames[31:0], stat_drops[15:0] and stat_errs[15:0], all reset to 0 and wrapping on overflow.
- stat_frames increments on each descriptor handshake.
- stat_drops increments per err_zero frame and per orphan cell.
- stat_errs increments per err_trunc.
REQ-032 Without SWITCH_POST_PW_STATS_EN, none of these ports or counters SHALL exist; all other behaviour is identical.

Verification
REQ-033 OUT_BYTES=4, one first+last cell with len=10, out_ready=1 -> 3 beats with keep 1111, 1111, 0011; out_last on beat 3; desc_len=10.
REQ-034 len=60 over 4 cells, out_ready toggling 50% -> 60 bytes in order, data stable while stalled, one descriptor with desc_len=60.
REQ-035 Non-first cell arriving in IDLE -> popped, err_orphan=1 for 1 clk, no out_valid.
REQ-036 len=40 but in_last on 2nd cell (30 payload bytes) -> 30 bytes emitted, err_trunc pulse, desc_len=30.
REQ-037 Hold desc_ready=0 while pushing 240 cells -> in_bp=1 at 240 entries, no second frame starts; release desc_ready -> frames resume.
REQ-038 Assert rstn low mid-STREAM -> all outputs 0 next clk; a following good frame is emitted correctly.

Source files
------------

// File: rtl/switch_post_pw.sv
// switch_post_pw: egress post-processor for switch cells.
// Buffers 128-bit cells in a first-word-fall-through FIFO. Each frame's
// payload (length taken from the first cell) is repacked into an
// OUT_BYTES-wide byte stream, and a length descriptor follows every frame.
// Optional statistics counters are enabled by defining SWITCH_POST_PW_STATS_EN.
module switch_post_pw #(
  parameter int unsigned OUT_BYTES  = 4,
  parameter int unsigned CELL_DEPTH = 256,
  parameter int unsigned BP_MARGIN  = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_wr,
  input  logic [127:0]           in_din,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   in_bp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*OUT_BYTES-1:0] out_data,
  output logic [OUT_BYTES-1:0]   out_keep,
  output logic                   out_last,
  output logic                   desc_valid,
  input  logic                   desc_ready,
  output logic [11:0]            desc_len,
  output logic                   err_orphan,
  output logic                   err_trunc,
  output logic                   err_zero
`ifdef SWITCH_POST_PW_STATS_EN
  ,
  output logic [31:0]            stat_frames,
  output logic [15:0]            stat_drops,
  output logic [15:0]            stat_errs
`endif
);

  localparam int unsigned AW = $clog2(CELL_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic         first;
    logic         last;
    logic [127:0] data;
  } cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_STREAM,
    S_FLUSH,
    S_DESC,
    S_DROP
  } state_e;

  // ---------------- cell FIFO ----------------
  cell_t         mem [CELL_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic [1:0]    pop_n;
  logic          in_bp_q;

  cell_t         head;
  logic [127:0]  nxt_data;
  logic          nxt_last;
  logic          head_v, next_v;

  assign push     = in_wr && (count_q != CW'(CELL_DEPTH));
  assign count_d  = count_q + CW'(push) - CW'(pop_n);
  assign rd_nxt   = rd_ptr_q + AW'(1);
  assign head     = mem[rd_ptr_q];
  assign nxt_data = mem[rd_nxt].data;
  assign nxt_last = mem[rd_nxt].last;
  assign head_v   = (count_q != '0);
  assign next_v   = (count_q > CW'(1));
  assign in_bp    = in_bp_q;

  // Cell storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_first, in_last, in_din};
  end

  // FIFO pointers, occupancy and registered backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      in_bp_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q <= rd_ptr_q + AW'(pop_n);
      count_q  <= count_d;
      in_bp_q  <= (32'(CELL_DEPTH) - 32'(count_d)) <= 32'(BP_MARGIN);
    end
  end

  // ---------------- beat builder ----------------
  state_e        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [11:0]   len_q, len_d;
  logic [11:0]   emit_q, emit_d;

  logic [7:0]    hb [16];
  logic [7:0]    nb [16];
  logic [11:0]   rem;
  logic [4:0]    n_want, avail, n, new_pos, idx;
  logic          use_next, beat_ok, frame_end, trunc, end_last;
  logic [8*OUT_BYTES-1:0] beat_data;
  logic [OUT_BYTES-1:0]   beat_keep;
  logic          fire;

  // Split head and next cells into byte arrays (byte0 is the MSB byte).
  always_comb begin
    for (int unsigned k = 0; k < 16; k++) begin
      hb[k] = head.data[127-8*k -: 8];
      nb[k] = nxt_data[127-8*k -: 8];
    end
  end

  // A beat takes min(OUT_BYTES, remaining) bytes; it borrows from the next
  // cell only when the head is not the frame's last cell, otherwise the
  // frame is cut short at the end of the head cell.
  always_comb begin
    rem       = len_q - emit_q;
    n_want    = (rem < 12'(OUT_BYTES)) ? rem[4:0] : 5'(OUT_BYTES);
    avail     = 5'd16 - {1'b0, pos_q};
    n         = n_want;
    use_next  = 1'b0;
    beat_ok   = 1'b0;
    if (n_want <= avail) begin
      beat_ok = head_v;
    end else if (head.last) begin
      n       = avail;
      beat_ok = head_v;
    end else begin
      use_next = 1'b1;
      beat_ok  = next_v;
    end
    frame_end = (12'(n) == rem) || (head.last && !use_next && (n == avail));
    trunc     = frame_end && (12'(n) != rem);
    end_last  = use_next ? nxt_last : head.last;
    new_pos   = {1'b0, pos_q} + n;
    beat_data = '0;
    beat_keep = '0;
    idx       = '0;
    for (int unsigned j = 0; j < OUT_BYTES; j++) begin
      if (5'(j) < n) begin
        idx                = {1'b0, pos_q} + 5'(j);
        beat_data[8*j +: 8] = idx[4] ? nb[idx[3:0]] : hb[idx[3:0]];
        beat_keep[j]       = 1'b1;
      end
    end
  end

  assign out_valid  = (state_q == S_STREAM) && beat_ok;
  assign out_data   = out_valid ? beat_data : '0;
  assign out_keep   = out_valid ? beat_keep : '0;
  assign out_last   = out_valid && frame_end;
  assign fire       = out_valid && out_ready;
  assign desc_valid = (state_q == S_DESC);
  assign desc_len   = desc_valid ? emit_q : '0;

  // ---------------- frame FSM ----------------
  logic orphan_ev, zero_ev, trunc_ev;
  logic err_orphan_q, err_trunc_q, err_zero_q;

  // Next-state, pop control and frame bookkeeping.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    len_d     = len_q;
    emit_d    = emit_q;
    pop_n     = 2'd0;
    orphan_ev = 1'b0;
    zero_ev   = 1'b0;
    trunc_ev  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (head_v) begin
          if (!head.first) begin
            pop_n     = 2'd1;
            orphan_ev = 1'b1;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        len_d  = {head.data[127:124], head.data[119:112]};
        emit_d = '0;
        pos_d  = 4'd2;
        if (len_d == '0) begin
          zero_ev = 1'b1;
          state_d = S_DROP;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (fire) begin
          emit_d = emit_q + 12'(n);
          if (frame_end) begin
            // The cell holding the final byte may be the borrowed next cell,
            // so up to two cells retire together.
            pop_n    = use_next ? 2'd2 : 2'd1;
            trunc_ev = trunc;
            state_d  = end_last ? S_DESC : S_FLUSH;
          end else begin
            pop_n = new_pos[4] ? 2'd1 : 2'd0;
            pos_d = new_pos[3:0];
          end
        end
      end
      S_FLUSH, S_DROP: begin
        if (head_v) begin
          pop_n = 2'd1;
          if (head.last) state_d = (state_q == S_FLUSH) ? S_DESC : S_IDLE;
        end
      end
      S_DESC: begin
        if (desc_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, frame registers and error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      pos_q        <= '0;
      len_q        <= '0;
      emit_q       <= '0;
      err_orphan_q <= 1'b0;
      err_trunc_q  <= 1'b0;
      err_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      len_q        <= len_d;
      emit_q       <= emit_d;
      err_orphan_q <= orphan_ev;
      err_trunc_q  <= trunc_ev;
      err_zero_q   <= zero_ev;
    end
  end

  assign err_orphan = err_orphan_q;
  assign err_trunc  = err_trunc_q;
  assign err_zero   = err_zero_q;

`ifdef SWITCH_POST_PW_STATS_EN
  logic [31:0] stat_frames_q;
  logic [15:0] stat_drops_q, stat_errs_q;

  // Wrapping event counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_frames_q <= '0;
      stat_drops_q  <= '0;
      stat_errs_q   <= '0;
    end else begin
      if (desc_valid && desc_ready) stat_frames_q <= stat_frames_q + 32'd1;
      if (zero_ev || orphan_ev)     stat_drops_q  <= stat_drops_q + 16'd1;
      if (trunc_ev)                 stat_errs_q   <= stat_errs_q + 16'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_drops  = stat_drops_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_switch_post_pw.sv
// Testbench for switch_post_pw: directed and random cell streams checked
// against a frame-level parser of the pushed cells.
module tb_switch_post_pw;
  localparam int OB = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_wr = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [127:0]      in_din = '0;
  logic              in_bp;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;
  logic [8*OB-1:0]   out_data;
  logic [OB-1:0]     out_keep;
  logic              desc_valid;
  logic              desc_ready = 1'b0;
  logic [11:0]       desc_len;
  logic              err_orphan, err_trunc, err_zero;
`ifdef SWITCH_POST_PW_STATS_EN
  logic [31:0]       stat_frames;
  logic [15:0]       stat_drops, stat_errs;
`endif

  switch_post_pw #(.OUT_BYTES(OB), .CELL_DEPTH(256), .BP_MARGIN(16)) dut (
    .clk(clk), .rstn(rstn), .in_wr(in_wr), .in_din(in_din),
    .in_first(in_first), .in_last(in_last), .in_bp(in_bp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_len(desc_len),
    .err_orphan(err_orphan), .err_trunc(err_trunc), .err_zero(err_zero)
`ifdef SWITCH_POST_PW_STATS_EN
    , .stat_frames(stat_frames), .stat_drops(stat_drops), .stat_errs(stat_errs)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         first;
    bit         last;
    bit [127:0] data;
  } cell_s;

  cell_s           cq[$];
  byte unsigned    exp_bytes[$];
  int              exp_flen[$];
  int              exp_desc[$];
  int              left = 0;
  int              exp_orph = 0, exp_trunc = 0, exp_zero = 0;
  int              obs_orph = 0, obs_trunc = 0, obs_zero = 0;
  int              beats_seen = 0;
  int              total = 0, bad = 0;
  bit              ready_mode = 1'b0;
  bit              desc_hold = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: parse the cell list as the switch would frame it.
  task automatic run_model();
    int i, k, p, cnt, L;
    i = 0;
    while (i < cq.size()) begin
      if (!cq[i].first) begin
        exp_orph++;
        i++;
      end else begin
        L = int'({cq[i].data[127:124], cq[i].data[119:112]});
        k = i;
        if (L == 0) begin
          exp_zero++;
        end else begin
          cnt = 0;
          p   = 2;
          forever begin
            exp_bytes.push_back(cq[k].data[127-8*p -: 8]);
            cnt++;
            p++;
            if (cnt == L) break;
            if (p == 16) begin
              if (cq[k].last) begin
                exp_trunc++;
                break;
              end
              k++;
              p = 0;
            end
          end
          exp_flen.push_back(cnt);
          exp_desc.push_back(cnt);
        end
        while (!cq[k].last) k++;
        i = k + 1;
      end
    end
  endtask

  task automatic gen_cells(input int L, input int n);
    cell_s c;
    for (int ci = 0; ci < n; ci++) begin
      c.data  = {$urandom, $urandom, $urandom, $urandom};
      c.first = (ci == 0);
      c.last  = (ci == n - 1);
      if (ci == 0) begin
        c.data[127:124] = 4'(L >> 8);
        c.data[119:112] = 8'(L);
      end
      cq.push_back(c);
    end
  endtask

  task automatic gen_random_frame();
    int kind, L, n;
    cell_s c;
    kind = int'($urandom_range(0, 4));
    case (kind)
      0: begin L = int'($urandom_range(1, 100)); gen_cells(L, (L + 17) / 16); end
      1: begin L = int'($urandom_range(1, 100)); gen_cells(L, (L + 17) / 16 + int'($urandom_range(1, 2))); end
      2: begin n = int'($urandom_range(1, 3)); gen_cells(16 * n - 2 + int'($urandom_range(1, 20)), n); end
      3: gen_cells(0, int'($urandom_range(1, 3)));
      default: begin
        c.data  = {$urandom, $urandom, $urandom, $urandom};
        c.first = 1'b0;
        c.last  = 1'($urandom_range(0, 1));
        cq.push_back(c);
      end
    endcase
  endtask

  task automatic push_all(input bit gaps);
    int guard;
    foreach (cq[i]) begin
      guard = 0;
      while (in_bp && guard < 5000) begin
        @(posedge clk); #1;
        guard++;
      end
      in_wr    = 1'b1;
      in_din   = cq[i].data;
      in_first = cq[i].first;
      in_last  = cq[i].last;
      @(posedge clk); #1;
      in_wr = 1'b0;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge clk); #1;
      end
    end
    cq.delete();
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((exp_flen.size() != 0 || left != 0 || exp_desc.size() != 0) && g < 20000) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq({tag, "_drain"}, 64'(g < 20000), 1);
    repeat (20) @(posedge clk);
    #1;
    check_eq({tag, "_orphan_cnt"}, obs_orph, exp_orph);
    check_eq({tag, "_trunc_cnt"}, obs_trunc, exp_trunc);
    check_eq({tag, "_zero_cnt"}, obs_zero, exp_zero);
  endtask

  // Ready drivers.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready  = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      desc_ready = desc_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Output monitor and scoreboard.
  logic [8*OB-1:0] hold_data;
  logic [OB-1:0]   hold_keep;
  logic            hold_last;
  bit              stalled = 1'b0;
  initial begin
    int k;
    logic [8*OB-1:0] ed, mask;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_beat", {out_data, out_keep, out_last}, {hold_data, hold_keep, hold_last});
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_keep = out_keep;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        beats_seen++;
        if (left == 0) begin
          if (exp_flen.size() == 0) check_eq("beat_unexpected", 1, 0);
          else left = exp_flen.pop_front();
        end
        if (left > 0) begin
          k    = (left < OB) ? left : OB;
          ed   = '0;
          mask = '0;
          for (int j = 0; j < k; j++) begin
            ed[8*j +: 8]   = exp_bytes.pop_front();
            mask[8*j +: 8] = 8'hFF;
          end
          check_eq("beat_keep", out_keep, 64'((1 << k) - 1));
          check_eq("beat_data", out_data & mask, ed);
          check_eq("beat_last", out_last, 64'(k == left));
          left -= k;
        end
      end
      if (desc_valid && desc_ready) begin
        if (exp_desc.size() == 0) check_eq("desc_unexpected", 1, 0);
        else check_eq("desc_len", desc_len, exp_desc.pop_front());
      end
      obs_orph  += int'(err_orphan);
      obs_trunc += int'(err_trunc);
      obs_zero  += int'(err_zero);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, g, b0;
    cell_s c;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_bp", in_bp, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_desc_valid", desc_valid, 0);
    check_eq("rst_desc_len", desc_len, 0);
    check_eq("rst_errs", {err_orphan, err_trunc, err_zero}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single cell, len=10, ready always high; also measures first-beat latency.
    ready_mode = 1'b0;
    gen_cells(10, 1);
    run_model();
    c        = cq[0];
    in_wr    = 1'b1;
    in_din   = c.data;
    in_first = c.first;
    in_last  = c.last;
    @(posedge clk); #1;
    in_wr = 1'b0;
    cq.delete();
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
    @(posedge clk); #1;
    check_eq("first_beat_latency", lat, 2);
    drain("len10");

    // Truncated frame: len=40, only 30 payload bytes before in_last.
    gen_cells(40, 2);
    run_model();
    push_all(1'b0);
    drain("trunc");

    // Orphan cell in IDLE.
    c.data = {$urandom, $urandom, $urandom, $urandom};
    c.first = 1'b0;
    c.last  = 1'b1;
    cq.push_back(c);
    run_model();
    b0 = beats_seen;
    push_all(1'b0);
    drain("orphan");
    check_eq("orphan_no_beats", beats_seen, b0);

    // len=60 over 4 cells with out_ready toggling.
    ready_mode = 1'b1;
    gen_cells(60, 4);
    run_model();
    push_all(1'b0);
    drain("len60");

    // Random mix of good, flushed, truncated, zero-length and orphan traffic.
    for (int f = 0; f < 80; f++) gen_random_frame();
    run_model();
    push_all(1'b1);
    drain("random");

    // Backpressure while the descriptor is held.
    ready_mode = 1'b0;
    desc_hold  = 1'b1;
    @(posedge clk); #1;
    gen_cells(5, 1);
    run_model();
    push_all(1'b0);
    g = 0;
    while (!desc_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("bp_desc_wait", 64'(g < 100), 1);
    for (int f = 0; f < 240; f++) gen_cells(int'($urandom_range(1, 14)), 1);
    run_model();
    b0 = beats_seen;
    foreach (cq[i]) begin
      in_wr    = 1'b1;
      in_din   = cq[i].data;
      in_first = cq[i].first;
      in_last  = cq[i].last;
      @(posedge clk); #1;
      in_wr = 1'b0;
      if (i == 238) check_eq("bp_at_239", in_bp, 0);
      if (i == 239) check_eq("bp_at_240", in_bp, 1);
    end
    cq.delete();
    repeat (10) @(posedge clk);
    #1;
    check_eq("bp_no_second_frame", beats_seen, b0);
    check_eq("bp_desc_held", desc_valid, 1);
    desc_hold = 1'b0;
    drain("bp");
    check_eq("bp_released", in_bp, 0);

    // Reset in the middle of streaming, then a clean frame.
    ready_mode = 1'b1;
    gen_cells(90, 6);
    run_model();
    b0 = beats_seen;
    push_all(1'b0);
    g = 0;
    while (beats_seen < b0 + 3 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check_eq("rst_mid_wait", 64'(g < 200), 1);
    rstn = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    check_eq("mid_rst_out_keep", out_keep, 0);
    check_eq("mid_rst_out_last", out_last, 0);
    check_eq("mid_rst_desc", {desc_valid, desc_len}, 0);
    check_eq("mid_rst_in_bp", in_bp, 0);
    check_eq("mid_rst_errs", {err_orphan, err_trunc, err_zero}, 0);
    exp_bytes.delete();
    exp_flen.delete();
    exp_desc.delete();
    left = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    gen_cells(30, 2);
    run_model();
    push_all(1'b0);
    drain("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
